// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one cache-line memory port between the icache (port 0) and the dcache (port 1).
// Round-robin by default; define ARB_FIXED_PRIORITY_EN to give port 1 strict priority. dbg_state_o: 0=IDLE 1=BUSY 2=RELEASE.

module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 256,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_enable_i,
    input  logic              m0_write_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic [DATA_W-1:0] m0_data_o,
    output logic              m0_ack_o,
    input  logic              m1_enable_i,
    input  logic              m1_write_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic [DATA_W-1:0] m1_data_o,
    output logic              m1_ack_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [1:0]        grant_o,
    output logic              timeout_o,
    output logic [1:0]        dbg_state_o
);
    // Handshake: a requester raises mN_enable_i and holds it (with write/addr/data stable) until its
    // mN_ack_o pulse; the memory sees mem_enable_o for the whole transaction and answers with one mem_ack_i.

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    localparam int               CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_t           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             any_req;
    logic             pick1;
    logic             busy;

    assign any_req = m0_enable_i | m1_enable_i;

`ifdef ARB_FIXED_PRIORITY_EN
    assign pick1 = m1_enable_i;
`else
    // last_q is the index of the port served most recently; on a tie the other port wins.
    logic last_q, last_d;

    assign pick1 = m1_enable_i & (~m0_enable_i | ~last_q);

    always_comb begin
        last_d = last_q;
        if (state_q == S_IDLE && any_req) begin
            last_d = pick1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d = S_BUSY;
                    grant_d = pick1 ? 2'b10 : 2'b01;
                    cnt_d   = '0;
                end
            end
            S_BUSY: begin
                // Counter saturates so a hung transaction cannot wrap back below the limit.
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (TIMEOUT != 0 && cnt_d == CNT_MAX) begin
                    timeout_d = 1'b1;
                end
                if (mem_ack_i) begin
                    state_d = S_RELEASE;
                    grant_d = 2'b00;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            grant_q   <= 2'b00;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign busy         = (state_q == S_BUSY);
    assign mem_enable_o = busy;
    assign mem_write_o  = busy & (grant_q[1] ? m1_write_i : m0_write_i);
    assign mem_addr_o   = busy ? (grant_q[1] ? m1_addr_i : m0_addr_i) : '0;
    assign mem_data_o   = busy ? (grant_q[1] ? m1_data_i : m0_data_i) : '0;

    // Read data fans out to both ports; only the acked owner consumes it.
    assign m0_data_o   = mem_data_i;
    assign m1_data_o   = mem_data_i;
    assign m0_ack_o    = mem_ack_i & grant_q[0];
    assign m1_ack_o    = mem_ack_i & grant_q[1];
    assign grant_o     = grant_q;
    assign timeout_o   = timeout_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: reset checks, a vector table for arbitration order, hand-written
// multi-cycle sequences, and a randomized run against a transaction-level model.

module tb_mem_port_arbiter;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         m0_enable_i, m0_write_i, m1_enable_i, m1_write_i;
    logic [31:0]  m0_addr_i, m1_addr_i;
    logic [255:0] m0_data_i, m1_data_i, m0_data_o, m1_data_o;
    logic         m0_ack_o, m1_ack_o;
    logic         mem_enable_o, mem_write_o, mem_ack_i;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o, mem_data_i;
    logic [1:0]   grant_o, dbg_state_o;
    logic         timeout_o;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(256), .TIMEOUT(15)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_enable_i(m0_enable_i), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i),
        .m0_data_i(m0_data_i), .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
        .m1_enable_i(m1_enable_i), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i),
        .m1_data_i(m1_data_i), .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .grant_o(grant_o), .timeout_o(timeout_o), .dbg_state_o(dbg_state_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        m0_enable_i = 1'b0; m0_write_i = 1'b0; m0_addr_i = '0; m0_data_i = '0;
        m1_enable_i = 1'b0; m1_write_i = 1'b0; m1_addr_i = '0; m1_data_i = '0;
        mem_ack_i = 1'b0; mem_data_i = '0;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    typedef struct packed {
        logic       m0, m1, ack;
        logic       en;
        logic [1:0] gnt;
        logic       a0, a1;
    } vec_t;
    vec_t tv[$];

    task automatic add_vec(input logic m0, m1, ack, en, input logic [1:0] gnt, input logic a0, a1);
        vec_t v;
        v.m0 = m0; v.m1 = m1; v.ack = ack; v.en = en; v.gnt = gnt; v.a0 = a0; v.a1 = a1;
        tv.push_back(v);
    endtask

    // Transaction-level reference model state.
    bit           pend[2];
    int           dly[2];
    logic [31:0]  ra[2];
    logic [255:0] rd[2];
    bit           rw[2];
    int           owner, lat, avail, last_served, pick, n_wait, gap;
    bit           busy_m, ack_drv, flag;
    logic [255:0] d_wb, rdata;

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        #1;
        check("reset_outputs", 256'({mem_enable_o, mem_write_o, m0_ack_o, m1_ack_o, grant_o, timeout_o}), 256'(0));
        check("reset_bus", 256'({mem_addr_o, mem_data_o}), 256'(0));
        check("reset_state", 256'(dbg_state_o), 256'(0));

        // ---------------- vector table: arbitration order ----------------
        // columns: m0_en m1_en mem_ack | mem_en grant m0_ack m1_ack
`ifdef ARB_FIXED_PRIORITY_EN
        add_vec(1,1,0, 0,2'b00,0,0);
        add_vec(1,1,0, 1,2'b10,0,0);
        add_vec(1,1,1, 1,2'b10,0,1);
        add_vec(1,1,0, 0,2'b00,0,0);
        add_vec(1,1,0, 0,2'b00,0,0);
        add_vec(1,1,0, 1,2'b10,0,0);
        add_vec(1,1,1, 1,2'b10,0,1);
        add_vec(1,0,0, 0,2'b00,0,0);
        add_vec(1,0,0, 0,2'b00,0,0);
        add_vec(1,0,1, 1,2'b01,1,0);
`else
        add_vec(1,1,0, 0,2'b00,0,0);
        add_vec(1,1,0, 1,2'b01,0,0);
        add_vec(1,1,1, 1,2'b01,1,0);
        add_vec(0,1,0, 0,2'b00,0,0);
        add_vec(0,1,0, 0,2'b00,0,0);
        add_vec(1,1,0, 1,2'b10,0,0);
        add_vec(1,1,1, 1,2'b10,0,1);
        add_vec(1,1,0, 0,2'b00,0,0);
        add_vec(1,1,0, 0,2'b00,0,0);
        add_vec(1,1,1, 1,2'b01,1,0);
`endif
        add_vec(0,1,1, 0,2'b00,0,0);
        add_vec(0,0,1, 0,2'b00,0,0);
        add_vec(0,0,0, 0,2'b00,0,0);
        do_reset();
        m0_write_i = 1'b0; m0_addr_i = 32'h100;
        m1_write_i = 1'b1; m1_addr_i = 32'h200;
        for (int i = 0; i < tv.size(); i++) begin
            m0_enable_i = tv[i].m0; m1_enable_i = tv[i].m1; mem_ack_i = tv[i].ack;
            #1;
            check($sformatf("vec%0d", i),
                  256'({mem_enable_o, grant_o, m0_ack_o, m1_ack_o, mem_write_o}),
                  256'({tv[i].en, tv[i].gnt, tv[i].a0, tv[i].a1, tv[i].gnt[1]}));
            tick();
        end

        // ---------------- single read, port 0 ----------------
        do_reset();
        m0_enable_i = 1'b1; m0_write_i = 1'b0; m0_addr_i = 32'h0000_0400;
        #1;
        check("rd_cycle0_idle", 256'(mem_enable_o), 256'(0));
        tick(); #1;
        check("rd_cycle1_req", 256'({mem_enable_o, mem_addr_o}), 256'({1'b1, 32'h400}));
        flag = 1'b0;
        for (int c = 2; c <= 10; c++) begin
            tick(); #1;
            if (!mem_enable_o || m0_ack_o || m1_ack_o) flag = 1'b1;
        end
        check("rd_wait_busy", 256'(flag), 256'(0));
        tick();
        mem_ack_i = 1'b1; mem_data_i = {32{8'hA5}};
        #1;
        check("rd_ack", 256'({m0_ack_o, m1_ack_o}), 256'(2'b10));
        check("rd_data", m0_data_o, {32{8'hA5}});
        tick();
        mem_ack_i = 1'b0; m0_enable_i = 1'b0;
        #1;
        check("rd_cycle12_release", 256'({mem_enable_o, grant_o, m1_ack_o}), 256'(0));

        // ---------------- port 1 writeback then fill ----------------
        do_reset();
        d_wb = rand256();
        m1_enable_i = 1'b1; m1_write_i = 1'b1; m1_addr_i = 32'h0000_1C20; m1_data_i = d_wb;
        #1;
        n_wait = 0;
        while (!mem_enable_o && n_wait < 20) begin tick(); #1; n_wait++; end
        check("wb_grant_latency", 256'(n_wait), 256'(1));
        check("wb_bus", 256'({mem_write_o, mem_addr_o, grant_o}), 256'({1'b1, 32'h1C20, 2'b10}));
        check("wb_data", mem_data_o, d_wb);
        tick(); tick();
        mem_ack_i = 1'b1;
        #1;
        check("wb_ack", 256'({m0_ack_o, m1_ack_o}), 256'(2'b01));
        tick();
        mem_ack_i = 1'b0; m1_write_i = 1'b0; m1_addr_i = 32'h0000_0820; m1_data_i = rand256();
        #1;
        gap = 0;
        while (!mem_enable_o && gap < 20) begin gap++; tick(); #1; end
        check("fill_gap", 256'(gap), 256'(2));
        check("fill_bus", 256'({mem_write_o, mem_addr_o}), 256'({1'b0, 32'h0820}));
        mem_ack_i = 1'b1; mem_data_i = rand256();
        #1;
        check("fill_ack", 256'({m1_ack_o, m1_data_o}), 256'({1'b1, mem_data_i}));
        tick();
        mem_ack_i = 1'b0; m1_enable_i = 1'b0;

        // ---------------- reset during BUSY ----------------
        do_reset();
        m0_enable_i = 1'b1;
        for (int c = 1; c <= 5; c++) tick();
        #1;
        check("rstbusy_pre", 256'({mem_enable_o, grant_o}), 256'({1'b1, 2'b01}));
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0; m0_enable_i = 1'b0;
        #1;
        check("rstbusy_after", 256'({mem_enable_o, grant_o, dbg_state_o}), 256'(0));
        tick(); tick();
        mem_ack_i = 1'b1;
        #1;
        check("rstbusy_stray_ack", 256'({m0_ack_o, m1_ack_o, grant_o}), 256'(0));
        tick();
        mem_ack_i = 1'b0;

        // ---------------- watchdog (TIMEOUT = 15) ----------------
        do_reset();
        m0_enable_i = 1'b1;
        for (int c = 1; c <= 15; c++) tick();
        #1;
        check("wd_before", 256'({mem_enable_o, timeout_o}), 256'(2'b10));
        tick(); #1;
        check("wd_rise", 256'(timeout_o), 256'(1));
        m0_enable_i = 1'b0;
        repeat (20) tick();
        #1;
        check("wd_sticky_busy", 256'({mem_enable_o, timeout_o}), 256'(2'b11));
        mem_ack_i = 1'b1;
        #1;
        check("wd_ack_after_withdraw", 256'(m0_ack_o), 256'(1));
        tick();
        mem_ack_i = 1'b0;
        #1;
        check("wd_hold_idle", 256'(timeout_o), 256'(1));
        do_reset();
        #1;
        check("wd_cleared_by_reset", 256'(timeout_o), 256'(0));

        // ---------------- randomized run against transaction model ----------------
        do_reset();
        owner = -1; lat = 0; avail = 0; last_served = 1;
        for (int p = 0; p < 2; p++) begin pend[p] = 1'b0; dly[p] = $urandom_range(0, 3); end
        for (int c = 0; c < 600; c++) begin
            busy_m  = (owner >= 0);
            ack_drv = busy_m ? (lat == 0) : ($urandom_range(0, 3) == 0);
            m0_enable_i = pend[0]; m0_write_i = rw[0]; m0_addr_i = ra[0]; m0_data_i = rd[0];
            m1_enable_i = pend[1]; m1_write_i = rw[1]; m1_addr_i = ra[1]; m1_data_i = rd[1];
            rdata = rand256();
            mem_ack_i = ack_drv; mem_data_i = rdata;
            #1;
            check("rnd_enable", 256'(mem_enable_o), 256'(busy_m));
            check("rnd_grant", 256'(grant_o), busy_m ? 256'(owner == 1 ? 2 : 1) : 256'(0));
            check("rnd_acks", 256'({m0_ack_o, m1_ack_o}),
                  256'({busy_m && ack_drv && owner == 0, busy_m && ack_drv && owner == 1}));
            if (busy_m) begin
                check("rnd_addr_wr", 256'({mem_write_o, mem_addr_o}), 256'({rw[owner], ra[owner]}));
                check("rnd_wdata", mem_data_o, rd[owner]);
                if (ack_drv) check("rnd_rdata", owner == 1 ? m1_data_o : m0_data_o, rdata);
            end else begin
                check("rnd_idle_bus", 256'({mem_write_o, mem_addr_o}), 256'(0));
                check("rnd_idle_wdata", mem_data_o, 256'(0));
            end
            if (busy_m) begin
                if (ack_drv) begin
                    pend[owner] = 1'b0;
                    dly[owner]  = $urandom_range(0, 3);
                    avail       = c + 2;
                    owner       = -1;
                end else begin
                    lat--;
                end
            end else if (c >= avail && (pend[0] || pend[1])) begin
`ifdef ARB_FIXED_PRIORITY_EN
                pick = pend[1] ? 1 : 0;
`else
                if (pend[0] && pend[1]) pick = 1 - last_served;
                else pick = pend[1] ? 1 : 0;
`endif
                last_served = pick;
                owner = pick;
                lat   = $urandom_range(0, 7);
            end
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && c < 540) begin
                    if (dly[p] == 0) begin
                        pend[p] = 1'b1;
                        ra[p]   = $urandom;
                        rd[p]   = rand256();
                        rw[p]   = 1'($urandom_range(0, 1));
                    end else begin
                        dly[p]--;
                    end
                end
            end
            tick();
        end
        #1;
        check("rnd_drained", 256'({mem_enable_o, grant_o}), 256'(0));
        check("rnd_no_timeout", 256'(timeout_o), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 256-bit data memory port between two cache requesters: port 0 = instruction cache, port 1 = data cache.
- Sits between the two cache controllers and the data memory model.
- Each requester uses the same enable/write/addr/data/ack protocol the caches already drive.
- Sequences one memory transaction at a time: grant, forward, wait for ack, then one turnaround cycle.

Parameters:
- ADDR_W, 32, memory address width.
- DATA_W, 256, cache line width.
- TIMEOUT, 1023, max cycles in BUSY before timeout_o latches; 0 disables the watchdog.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- m0_enable_i  in  1  port 0 request; held high until its ack
- m0_write_i  in  1  port 0 write (1) / read (0)
- m0_addr_i  in  ADDR_W  port 0 line address
- m0_data_i  in  DATA_W  port 0 write data
- m0_data_o  out  DATA_W  read data to port 0
- m0_ack_o  out  1  port 0 completion pulse
- m1_enable_i, m1_write_i, m1_addr_i, m1_data_i, m1_data_o, m1_ack_o: same as port 0, for port 1
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  memory write
- mem_addr_o  out  ADDR_W  memory address
- mem_data_o  out  DATA_W  memory write data
- mem_data_i  in  DATA_W  memory read data
- mem_ack_i  in  1  memory completion pulse (1 cycle)
- grant_o  out  2  one-hot current owner; 00 when none
- timeout_o  out  1  sticky watchdog flag

Behaviour:
- Reset (rst_i high at a posedge):
  - state=IDLE, grant=00, last-served pointer=1 (port 0 wins the first tie), busy counter=0, timeout_o=0.
  - All outputs low: mem_enable_o, mem_write_o, m0_ack_o, m1_ack_o.
  - Reset mid-transaction aborts immediately; a later mem_ack_i while in IDLE is ignored.
- States: IDLE, BUSY, RELEASE.
- IDLE:
  - If any mN_enable_i is high at the edge, register a one-hot grant and go to BUSY.
  - mem_enable_o rises the cycle after the request is sampled (1-cycle grant latency).
  - Otherwise stay in IDLE.
- Arbitration: round-robin.
  - With both requesting, grant the port not served last.
  - With one requesting, grant it.
  - The pointer updates when the grant is issued.
- BUSY:
  - mem_enable_o=1.
  - mem_write_o, mem_addr_o and mem_data_o are muxed combinationally from the granted port.
  - mem_data_i is routed to both mN_data_o; only the granted port's data is meaningful.
  - mNack_o = mem_ack_i AND grant[N], combinational, same cycle as mem_ack_i.
  - On mem_ack_i, go to RELEASE.
- RELEASE:
  - Exactly one cycle with mem_enable_o=0 and grant=00.
  - Then IDLE; a pending request is re-arbitrated in that IDLE cycle.
  - Back-to-back transactions from one port (dirty writeback followed by line fill) therefore have a 2-cycle gap between ack and the next mem_enable_o.
- When not BUSY: mem_write_o=0, mem_addr_o=0, mem_data_o=0.
- Requester withdraws enable before its ack: protocol violation. The arbiter stays BUSY, keeps mem_enable_o high and still forwards the ack.
- mem_ack_i in IDLE or RELEASE: ignored, no mN_ack_o.
- Watchdog:
  - The busy counter increments each BUSY cycle and clears on entry to BUSY.
  - When the counter equals TIMEOUT (and TIMEOUT≠0), timeout_o sets and holds until reset.
  - Arbitration is unaffected by the watchdog.
- Ack to the losing requester never occurs; its enable simply stays high until granted.

Optional Feature:
- ARB_FIXED_PRIORITY_EN defined:
  - Port 1 (dcache) always wins when both request; the round-robin pointer is unused.
  - Port 0 can starve.
- Undefined: round-robin as above (default build).

Test Plan:
- Single read, port 0 only: m0_enable_i=1, write=0, addr=32'h0000_0400 at cycle 0.
  - mem_enable_o=1 and mem_addr_o=32'h400 at cycle 1.
  - Memory acks at cycle 11 with data 256'hA5…A5 -> m0_ack_o=1 and m0_data_o=A5…A5 at cycle 11.
  - mem_enable_o=0 at cycle 12; m1_ack_o never asserts.
- Simultaneous requests from reset: both enable at cycle 0.
  - Grant 01 (port 0) first.
  - After its ack, RELEASE, IDLE, then grant 10 (port 1).
  - A third round with both still requesting grants port 0 again.
- Port 1 dirty writeback then fill: write=1 to 32'h0000_1C20 with data D, then read 32'h0000_0820.
  - mem_write_o=1 with data D on the first transaction, 0 on the second.
  - Exactly 2 idle cycles between the first ack and the second mem_enable_o rising.
- Reset during BUSY: assert rst_i at cycle 5 of a transaction.
  - Next cycle: mem_enable_o=0 and grant_o=00.
  - A stray mem_ack_i at cycle 8 produces no m0_ack_o or m1_ack_o.
- Watchdog with TIMEOUT=15 and memory never acking:
  - timeout_o rises after 15 BUSY cycles and stays 1 until rst_i.
- ARB_FIXED_PRIORITY_EN defined, both ports requesting continuously:
  - Port 1 is granted on every arbitration; port 0 is never granted.
